// File: rtl/freq_synth_gen.sv
// Programmable 50% duty square-wave generator. A sequential restoring divider turns
// the requested frequency into a half-period in sys_clk cycles, applied at toggle edges.
module freq_synth_gen #(
    parameter int unsigned CLK_FRE = 50_000_000
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic [31:0] i_fre_set,
    input  logic        i_fre_load,
    output logic        o_busy,
    output logic        o_fre_out,
    output logic [31:0] o_half_cur
);

    localparam logic [31:0] DIVIDEND = 32'(CLK_FRE);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_bit;
    logic [32:0] r_div;
    logic [33:0] r_rem;
    logic [31:0] r_quo;      // dividend bits shift out of the top, quotient bits shift in
    logic        r_zero;
    logic [31:0] r_pend;
    logic        r_pend_vld;
    logic [31:0] r_half;
    logic [31:0] r_cnt;
    logic        r_fre_out;

    logic [33:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_result;
    logic        w_done;
    logic        w_at_end;
    logic        w_apply;

    assign w_rem_sh = {r_rem[32:0], r_quo[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_done   = (r_state == S_DONE);
    // Zero request means stop; a zero quotient clamps to the fastest output, CLK_FRE/2.
    assign w_result = r_zero ? 32'd0 : ((r_quo == 32'd0) ? 32'd1 : r_quo);

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_fre_load) w_state_nxt = S_DIV;
            S_DIV:   if (r_bit == 5'd31) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_div  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_bit  <= '0;
            r_zero <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (i_fre_load) begin
                r_div  <= {i_fre_set, 1'b0};
                r_zero <= (i_fre_set == 32'd0);
                r_rem  <= '0;
                r_quo  <= DIVIDEND;
                r_bit  <= '0;
            end
        end else if (r_state == S_DIV) begin
            r_rem <= w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
            r_quo <= {r_quo[30:0], w_ge};
            r_bit <= r_bit + 5'd1;
        end
    end

    // New half-periods only take over at a toggle boundary (or immediately when stopped).
    assign w_at_end = (r_cnt == r_half - 32'd1);
    assign w_apply  = r_pend_vld && ((r_half == 32'd0) || w_at_end);

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_half     <= '0;
            r_cnt      <= '0;
            r_fre_out  <= 1'b0;
        end else begin
            if (r_half == 32'd0) begin
                r_fre_out <= 1'b0;
                r_cnt     <= '0;
            end else if (w_at_end) begin
                r_cnt     <= '0;
                r_fre_out <= (w_apply && (r_pend == 32'd0)) ? 1'b0 : ~r_fre_out;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_apply) r_half <= r_pend;

            // A fresh result landing on the apply edge stays pending for the next boundary.
            if (w_done) begin
                r_pend     <= w_result;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_fre_out  = r_fre_out;
    assign o_half_cur = r_half;

endmodule

// File: doc/freq_synth_gen.md
# freq_synth_gen

Programmable square-wave generator: the transmit-side counterpart of the frequency meter. Takes a target frequency in Hz, computes the half-period in `sys_clk` cycles with an on-board sequential divider, and drives a 50 % duty square wave at that frequency. Output frequency changes are glitch-free. It sits beside the meter so the FPGA can source a known `clk_fx` for loopback self-test, or drive external stimulus.

## Interface
- `CLK_FRE`, 50_000_000: `sys_clk` frequency in Hz. Must fit in 32 bits.
- `sys_clk` in 1: system clock, all logic on the rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `fre_set` in 32: requested output frequency in Hz, unsigned.
- `fre_load` in 1: one-cycle request that samples `fre_set`.
- `busy` out 1: division in progress; `fre_load` is ignored while high.
- `fre_out` out 1: generated square wave, registered.
- `half_cur` out 32: half-period currently in use, in cycles. 0 means stopped.

## Operation
- States:
  - IDLE: `busy`=0; waits for `fre_load`.
  - DIV: 32 cycles; restoring divider, one quotient bit per cycle, MSB first.
  - DONE: 1 cycle; writes the result to the pending register and raises `pend_vld`.
- Transitions:
  - IDLE→DIV when `fre_load`=1; `fre_set` is captured on the same edge.
  - DIV→DONE after the 32nd iteration.
  - DONE→IDLE unconditionally.
- Division:
  - q = floor(`CLK_FRE` / (2·`fre_set`)).
  - Divisor is 33 bits wide (2·`fre_set` must not overflow); remainder register is 34 bits.
- Result mapping:
  - `fre_set`=0 → result 0 (stop). No division-by-zero hazard: the divide runs but its result is overridden.
  - q=0, i.e. `fre_set` > `CLK_FRE`/2 → result 1. This clamps the output to `CLK_FRE`/2.
  - Otherwise result = q.
- Generator, while `half_cur`≠0:
  - `cnt` counts 0..`half_cur`−1.
  - At `cnt`=`half_cur`−1: toggle `fre_out`, set `cnt`=0.
  - If `pend_vld` is set on that same edge: load `half_cur` from pending and clear `pend_vld`. New periods therefore only start at a toggle boundary, so no runt phases.
- Generator, while `half_cur`=0 (stopped):
  - `fre_out` held 0, `cnt` held 0.
  - A pending value is applied on the next edge after `pend_vld`; `fre_out` stays 0 on that edge.
- Applying a 0 result while running: takes effect at the next toggle boundary. On that edge `fre_out` is forced to 0 instead of toggled, and `cnt`=0.
- A second result before the first is applied simply overwrites pending; the last one wins.

## Timing
- Reset values:
  - `busy`=0, `fre_out`=0, `half_cur`=0, `cnt`=0, `pend_vld`=0, state=IDLE.
  - Reset mid-division aborts the divide and discards any pending value.
- Request accepted at edge k (`fre_load`=1 with state IDLE):
  - `busy`=1 from after edge k through edge k+33.
  - Pending value is written at edge k+33; `busy`=0 after edge k+33.
  - Next accept is possible at edge k+34.
- `fre_load` asserted while `busy`=1: no effect. No queuing.
- Start from stopped, with pending written at edge k+33:
  - `half_cur` loads at edge k+34, with `fre_out`=0 and `cnt`=0.
  - First rising edge of `fre_out` at edge k+34+`half_cur`.
- Period in steady state is 2·`half_cur` cycles, exactly 50 % duty.
- `fre_set` is only sampled on the accept edge; later changes are ignored until the next request.

## Test plan
All scenarios use `CLK_FRE`=50_000_000.
- Reset, then idle 100 cycles → `fre_out`=0, `busy`=0, `half_cur`=0.
- `fre_load` with `fre_set`=1_000_000 at edge k:
  - `busy` high for edges k+1..k+33.
  - `half_cur`=25 from edge k+34.
  - `fre_out` rises at k+59, period 50 cycles, high 25 cycles.
  - Loop output into the meter: it reports 1_000_000.
- Running at 1 MHz, then load 2_000_000 (q=12):
  - Switch occurs exactly at a toggle edge.
  - No phase shorter than 12 cycles; afterwards period is 24.
- `fre_set`=30_000_000 → `half_cur`=1, period 2 cycles. `fre_set`=0 while running → `fre_out` goes low at the next toggle boundary and stays low; `half_cur`=0.
- Pulse `fre_load` with `fre_set`=5 at edge k+10 while busy → ignored; the earlier request's result is the one applied.
- Assert `sys_rst` during DIV cycle 15:
  - All outputs return to reset values immediately; no pending value survives.
  - A fresh request afterwards gives a correct result.
